// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle control unit for the 8-bit, 4-register CPU.
// Owns the PC and sequences FETCH -> DECODE -> execute / address / memory /
// write-back, driving the instruction-memory, register-file, ALU and
// data-memory controls. Instruction format: op[7:6] rs[5:4] rt[3:2] rd/imm[1:0].
// Build option: define SINGLE_STEP_EN to add the step/waiting ports and an
// IDLE state that gates every instruction fetch on a step pulse.
module mc_ctrl #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef SINGLE_STEP_EN
    input  logic            step,
    output logic            waiting,
`endif
    input  logic [7:0]      instr,
    input  logic            mem_ready,
    output logic [PC_W-1:0] pc,
    output logic [7:0]      ir,
    output logic            ir_load,
    output logic            alu_src_imm,
    output logic            reg_dst_rt,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            halted,
    output logic            retired
);

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_ADD = 4'd2,
        ST_ADDR     = 4'd3,
        ST_MEM      = 4'd4,
        ST_WB       = 4'd5,
        ST_JUMP     = 4'd6,
        ST_HALT     = 4'd7
`ifdef SINGLE_STEP_EN
        ,
        ST_IDLE     = 4'd8
`endif
    } state_t;

    // State entered after reset and after each retired instruction.
`ifdef SINGLE_STEP_EN
    localparam state_t ST_NEXT = ST_IDLE;
`else
    localparam state_t ST_NEXT = ST_FETCH;
`endif

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] jump_target;
    logic            is_store;

    assign pc_inc      = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    assign jump_target = {pc_q[PC_W-1:6], ir_q[5:0]};
    assign is_store    = (ir_q[7:6] == 2'b10);

    assign pc = pc_q;
    assign ir = ir_q;

    // State, PC and instruction register; reset acts immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_NEXT;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state, PC/IR updates and control outputs for the current state.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        ir_load     = 1'b0;
        alu_src_imm = 1'b0;
        reg_dst_rt  = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        halted      = 1'b0;
        retired     = 1'b0;
`ifdef SINGLE_STEP_EN
        waiting     = 1'b0;
`endif
        case (state_q)
`ifdef SINGLE_STEP_EN
            ST_IDLE: begin
                waiting = 1'b1;
                if (step) state_d = ST_FETCH;
            end
`endif
            ST_FETCH: begin
                ir_load = 1'b1;
                ir_d    = instr;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (ir_q[7:6])
                    2'b00:   state_d = ST_EXEC_ADD;
                    2'b11:   state_d = ST_JUMP;
                    default: state_d = ST_ADDR;
                endcase
            end
            ST_EXEC_ADD: begin
                reg_write = 1'b1;
                pc_d      = pc_inc;
                retired   = 1'b1;
                state_d   = ST_NEXT;
            end
            ST_ADDR: begin
                alu_src_imm = 1'b1;
                state_d     = ST_MEM;
            end
            ST_MEM: begin
                // Request is a pure function of the state so it holds steady
                // for the whole stall; completion is taken from mem_ready.
                alu_src_imm = 1'b1;
                mem_read    = !is_store;
                mem_write   = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_d    = pc_inc;
                        retired = 1'b1;
                        state_d = ST_NEXT;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_write   = 1'b1;
                reg_dst_rt  = 1'b1;
                alu_src_imm = 1'b1;
                pc_d        = pc_inc;
                retired     = 1'b1;
                state_d     = ST_NEXT;
            end
            ST_JUMP: begin
                // A jump to itself is the halt idiom.
                retired = 1'b1;
                if (jump_target == pc_q) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d    = jump_target;
                    state_d = ST_NEXT;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
        // The reset state is FETCH (or IDLE); keep every control quiet while
        // rst_n is low so no fetch or write strobe escapes during reset.
        if (!rst_n) begin
            ir_load     = 1'b0;
            alu_src_imm = 1'b0;
            reg_dst_rt  = 1'b0;
            reg_write   = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            halted      = 1'b0;
            retired     = 1'b0;
`ifdef SINGLE_STEP_EN
            waiting     = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed test of mc_ctrl. Stimulus pushes the expected fetch
// addresses and retire events into queues; a monitor pops and compares them
// whenever the controller asserts ir_load or retired.
`timescale 1ns/1ps
module tb_mc_ctrl;

`ifdef SINGLE_STEP_EN
    localparam int STEP_OVH = 1;
`else
    localparam int STEP_OVH = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] instr;
    logic       mem_ready = 1'b1;
    logic [7:0] pc;
    logic [7:0] ir;
    logic       ir_load, alu_src_imm, reg_dst_rt, reg_write;
    logic       mem_read, mem_write, halted, retired;
`ifdef SINGLE_STEP_EN
    logic       step = 1'b1;
    logic       waiting;
`endif

    logic [7:0] prog [256];
    assign instr = prog[pc];

    mc_ctrl #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef SINGLE_STEP_EN
        .step        (step),
        .waiting     (waiting),
`endif
        .instr       (instr),
        .mem_ready   (mem_ready),
        .pc          (pc),
        .ir          (ir),
        .ir_load     (ir_load),
        .alu_src_imm (alu_src_imm),
        .reg_dst_rt  (reg_dst_rt),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .halted      (halted),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] ir;
    } ret_t;

    ret_t ret_q[$];
    int   fetch_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc;            // posedges since reset release; cycle index = cyc + 1
    int tcyc;           // running expected cycle count for queued instructions
    int n_strobe = 0;
    int n_reg_write = 0;
    int n_mem_write = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Cycle counter restarts on every reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Monitor: sample on the falling edge, compare against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ir_load || reg_write || mem_read || mem_write || retired) n_strobe++;
            if (reg_write) n_reg_write++;
            if (mem_write) n_mem_write++;
            if (ir_load) begin
                if (fetch_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL fetch_unexpected: got fetch at pc=%0d, expected none", pc);
                end else begin
                    check("fetch_pc", pc, fetch_q.pop_front());
                end
            end
            if (retired) begin
                if (ret_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL retire_unexpected: got retire ir=%02h cycle %0d, expected none", ir, cyc + 1);
                end else begin
                    ret_t e;
                    e = ret_q.pop_front();
                    $display("retire cycle=%0d ir=%02h pc=%0d", cyc + 1, ir, pc);
                    check("retire_cycle", cyc + 1, e.cyc);
                    check("retire_ir", ir, e.ir);
                end
            end
            if (reg_write) begin
                check("reg_dst_rt_on_write", reg_dst_rt, ir[7:6] == 2'b01);
                check("alu_src_on_write", alu_src_imm, ir[7:6] == 2'b01);
            end
            if (mem_read || mem_write) begin
                check("mem_dir", {mem_read, mem_write}, (ir[7:6] == 2'b10) ? 2'b01 : 2'b10);
                check("alu_src_in_mem", alu_src_imm, 1);
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fill_default();
        // Every untouched address holds a jump to itself, i.e. a halt.
        for (int i = 0; i < 256; i++) prog[i] = {2'b11, 6'(i)};
    endtask

    task automatic expect_instr(input int addr, input logic [7:0] op, input int len);
        tcyc += STEP_OVH + len;
        fetch_q.push_back(addr);
        ret_q.push_back('{tcyc, op});
    endtask

    // Called at posedge+1 (or time 0); returns just after release.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_pc", pc, 0);
        check("reset_ir", ir, 0);
        check("reset_outputs",
              {ir_load, alu_src_imm, reg_dst_rt, reg_write, mem_read, mem_write, halted, retired}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tcyc = 0;
        n_strobe = 0;
        n_reg_write = 0;
        n_mem_write = 0;
    endtask

    task automatic end_test(input string name);
        check({name, "_fetch_q_left"}, fetch_q.size(), 0);
        check({name, "_ret_q_left"}, ret_q.size(), 0);
        fetch_q.delete();
        ret_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Program run with mem_ready tied high, ending in a halt at pc=5.
        fill_default();
        prog[0] = 8'h69; prog[1] = 8'h55; prog[2] = 8'h6F; prog[3] = 8'h2C; prog[4] = 8'h91;
        mem_ready = 1'b1;
        do_reset();
        expect_instr(0, 8'h69, 5);   // cycle 5
        expect_instr(1, 8'h55, 5);   // cycle 10
        expect_instr(2, 8'h6F, 5);   // cycle 15
        expect_instr(3, 8'h2C, 3);   // cycle 18
        expect_instr(4, 8'h91, 4);   // cycle 22
        expect_instr(5, 8'hC5, 3);   // halt
        run(tcyc + 3);
        check("prog_pc", pc, 5);
        check("prog_halted", halted, 1);
        check("prog_reg_writes", n_reg_write, 4);
        end_test("prog");

        // Jump from 2 to 5, then halt at 5 with no further activity.
        fill_default();
        prog[0] = 8'h00; prog[1] = 8'h00; prog[2] = 8'hC5;
        do_reset();
        expect_instr(0, 8'h00, 3);
        expect_instr(1, 8'h00, 3);
        expect_instr(2, 8'hC5, 3);
        expect_instr(5, 8'hC5, 3);
        run(tcyc + 2);
        check("jump_halted", halted, 1);
        n_strobe = 0;
        run(20);
        check("halt_quiet_strobes", n_strobe, 0);
        check("halt_pc", pc, 5);
        check("halt_still", halted, 1);
        end_test("jump");

        // Store stalled three cycles in MEM.
        fill_default();
        prog[0] = 8'h91;
        mem_ready = 1'b0;
        do_reset();
        expect_instr(0, 8'h91, 7);
        expect_instr(1, 8'hC1, 3);
        run(6 + STEP_OVH);
        check("stall_mem_write", mem_write, 1);
        mem_ready = 1'b1;
        run(8);
        check("stall_mem_write_cycles", n_mem_write, 4);
        check("stall_pc", pc, 1);
        end_test("stall");

        // Reset in MEM of a stalled load.
        fill_default();
        prog[0] = 8'h69;
        mem_ready = 1'b0;
        do_reset();
        fetch_q.push_back(0);
        run(4 + STEP_OVH);
        check("mid_mem_read_before", mem_read, 1);
        rst_n = 1'b0;
        #1;
        check("mid_mem_read_drop", mem_read, 0);
        check("mid_reg_write", reg_write, 0);
        check("mid_reg_write_count", n_reg_write, 0);
        end_test("midreset");
        mem_ready = 1'b1;
        do_reset();
        check("post_reset_pc", pc, 0);
        expect_instr(0, 8'h69, 5);
        expect_instr(1, 8'hC1, 3);
        run(tcyc + 3);
        check("post_reset_final_pc", pc, 1);
        check("post_reset_reg_writes", n_reg_write, 1);
        end_test("postreset");

        // Walk the PC up to 255 and wrap through an add.
        fill_default();
        prog[0] = 8'hFF;   prog[63] = 8'h00;  prog[64] = 8'hFF;  prog[127] = 8'h00;
        prog[128] = 8'hFF; prog[191] = 8'h00; prog[192] = 8'hFF; prog[255] = 8'h00;
        do_reset();
        expect_instr(0,   8'hFF, 3);
        expect_instr(63,  8'h00, 3);
        expect_instr(64,  8'hFF, 3);
        expect_instr(127, 8'h00, 3);
        expect_instr(128, 8'hFF, 3);
        expect_instr(191, 8'h00, 3);
        expect_instr(192, 8'hFF, 3);
        expect_instr(255, 8'h00, 3);
        fetch_q.push_back(0);
        run(tcyc + STEP_OVH);
        check("wrap_pc", pc, 0);
        check("wrap_ir_load", ir_load, 1);
        run(1);
        end_test("wrap");

`ifdef SINGLE_STEP_EN
        // Three isolated step pulses, three instructions.
        fill_default();
        prog[0] = 8'h00; prog[1] = 8'h00; prog[2] = 8'h00;
        step = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            run(5);
            check("step_waiting", waiting, 1);
            step = 1'b1;
            fetch_q.push_back(k);
            ret_q.push_back('{cyc + 1 + 3, 8'h00});
            run(1);
            step = 1'b0;
        end
        run(10);
        check("step_waiting_end", waiting, 1);
        check("step_pc", pc, 3);
        end_test("step");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
